hazard_ctrl_unit: RTL and testbench

- Next-generation pipeline control unit for the 5-stage RV32I core.
- Decodes the ID-stage opcode into EX/MEM/WB control bits.
- Owns all pipeline hazard sequencing: load-use stall, parametrised mispredict flush, and ECALL-halt drain.
- Sits beside the ID stage. Drives PC/IF-ID write enables, the IF-ID flush, and the ID-EX bubble select.

---
 rtl/hazard_ctrl_unit_pkg.sv | 38 +++
 rtl/hazard_ctrl_unit_ctrl_decode.sv | 59 +++++
 rtl/hazard_ctrl_unit.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared constants for the RV32I pipeline hazard controller: opcodes,
// bubble encoding, hazard FSM state encoding and the decoded control flags.
package hazard_ctrl_unit_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_ECALL     = 7'b1110011;

  localparam logic [6:0] BUBBLE_ALU_OP = 7'b0110111;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef struct packed {
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic write_enable;
    logic is_ecall;
    logic branch;
    logic jal;
    logic jalr;
    logic pc_to_reg;
  } ctrl_flags_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_ctrl_decode.sv
// Combinational ID-stage opcode decode into ID/EX control flags and ALU class.
// Undefined opcodes decode to bubble controls.
module hazard_ctrl_unit_ctrl_decode
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int ALU_OP_W = 7
) (
  input  logic [6:0]          i_opcode,
  output logic [9:0]          o_flags,
  output logic [ALU_OP_W-1:0] o_alu_op
);

  ctrl_flags_t w_flags;
  logic [6:0]  w_alu_op;

  always_comb begin
    w_flags  = '0;
    w_alu_op = i_opcode;
    case (i_opcode)
      OPC_LOAD: begin
        w_flags.mem_read     = 1'b1;
        w_flags.mem_to_reg   = 1'b1;
        w_flags.alu_src      = 1'b1;
        w_flags.write_enable = 1'b1;
      end
      OPC_STORE: begin
        w_flags.mem_write = 1'b1;
        w_flags.alu_src   = 1'b1;
      end
      OPC_ARITH:     w_flags.write_enable = 1'b1;
      OPC_ARITH_IMM: begin
        w_flags.alu_src      = 1'b1;
        w_flags.write_enable = 1'b1;
      end
      OPC_BRANCH:    w_flags.branch = 1'b1;
      OPC_JAL: begin
        w_flags.alu_src      = 1'b1;
        w_flags.write_enable = 1'b1;
        w_flags.jal          = 1'b1;
        w_flags.pc_to_reg    = 1'b1;
      end
      OPC_JALR: begin
        w_flags.alu_src      = 1'b1;
        w_flags.write_enable = 1'b1;
        w_flags.jalr         = 1'b1;
        w_flags.pc_to_reg    = 1'b1;
      end
      OPC_ECALL: begin
        w_flags.alu_src  = 1'b1;
        w_flags.is_ecall = 1'b1;
      end
      default:       w_alu_op = BUBBLE_ALU_OP;
    endcase
  end

  assign o_flags  = w_flags;
  assign o_alu_op = ALU_OP_W'(w_alu_op);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline control unit: ID decode plus load-use stall, mispredict flush and
// ECALL drain/halt sequencing for the 5-stage RV32I core.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_IDX_W   = 5,
  parameter int ALU_OP_W    = 7,
  parameter int FLUSH_DEPTH = 1,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [6:0]           i_id_opcode,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic                 i_idex_mem_read,
  input  logic [REG_IDX_W-1:0] i_idex_rd,
  input  logic                 i_ex_mispredict,
  input  logic                 i_halt_req,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_ifid_flush,
  output logic                 o_idex_bubble,
  output logic                 o_mem_read,
  output logic                 o_mem_to_reg,
  output logic                 o_mem_write,
  output logic                 o_alu_src,
  output logic                 o_write_enable,
  output logic                 o_is_ecall,
  output logic                 o_branch,
  output logic                 o_jal,
  output logic                 o_jalr,
  output logic                 o_pc_to_reg,
  output logic [ALU_OP_W-1:0]  o_alu_op,
  output logic                 o_halted
);

  localparam int CNT_W = $clog2(max_int(FLUSH_DEPTH, DRAIN_DEPTH) + 1);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_halted;
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_pc_write;
  logic                w_ifid_write;
  logic                w_ifid_flush;
  logic                w_bubble;
  logic                w_bubble_out;
  logic                w_load_use;
  logic                w_ecall_halt;
  logic [9:0]          w_dec_flags;
  logic [ALU_OP_W-1:0] w_dec_alu_op;
  ctrl_flags_t         w_out_flags;

  hazard_ctrl_unit_ctrl_decode #(.ALU_OP_W(ALU_OP_W)) u_ctrl_decode (
    .i_opcode (i_id_opcode),
    .o_flags  (w_dec_flags),
    .o_alu_op (w_dec_alu_op)
  );

  // x0 never carries a real dependency, so rd==0 can not stall
  assign w_load_use = i_idex_mem_read && (i_idex_rd != '0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_idex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_idex_rd)));
  assign w_ecall_halt = (i_id_opcode == OPC_ECALL) && i_halt_req;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pc_write   = 1'b0;
    w_ifid_write = 1'b0;
    w_ifid_flush = 1'b0;
    w_bubble     = 1'b1;
    case (r_state)
      ST_RUN: begin
        if (i_ex_mispredict) begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = CNT_W'(FLUSH_DEPTH - 1);
          end
        end else if (w_load_use) begin
          w_bubble = 1'b1;
        end else if (w_ecall_halt) begin
          w_bubble    = 1'b0;
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_W'(DRAIN_DEPTH);
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_bubble     = 1'b0;
        end
      end
      ST_FLUSH: begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b1;
        if (i_ex_mispredict) begin
          w_cnt_nxt = CNT_W'(FLUSH_DEPTH - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_HALT;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_RUN;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_halted <= r_halted | (r_state == ST_HALT);
    end
  end

  // Reset held low overrides the FSM outputs combinationally
  assign w_bubble_out  = ~i_reset_n | w_bubble;
  assign o_pc_write    = i_reset_n & w_pc_write;
  assign o_ifid_write  = i_reset_n & w_ifid_write;
  assign o_ifid_flush  = ~i_reset_n | w_ifid_flush;
  assign o_idex_bubble = w_bubble_out;
  assign o_halted      = r_halted;

  assign w_out_flags    = w_bubble_out ? ctrl_flags_t'('0) : ctrl_flags_t'(w_dec_flags);
  assign o_alu_op       = w_bubble_out ? ALU_OP_W'(BUBBLE_ALU_OP) : w_dec_alu_op;
  assign o_mem_read     = w_out_flags.mem_read;
  assign o_mem_to_reg   = w_out_flags.mem_to_reg;
  assign o_mem_write    = w_out_flags.mem_write;
  assign o_alu_src      = w_out_flags.alu_src;
  assign o_write_enable = w_out_flags.write_enable;
  assign o_is_ecall     = w_out_flags.is_ecall;
  assign o_branch       = w_out_flags.branch;
  assign o_jal          = w_out_flags.jal;
  assign o_jalr         = w_out_flags.jalr;
  assign o_pc_to_reg    = w_out_flags.pc_to_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: two instances (FLUSH_DEPTH 3 and 1) fed the same stimulus,
// directed scenarios followed by a random run against a cycle-level reference model.
module tb_hazard_ctrl_unit;

  localparam logic [6:0] C_LOAD = 7'b0000011, C_STORE = 7'b0100011, C_ADD = 7'b0110011,
                         C_ADDI = 7'b0010011, C_BR = 7'b1100011, C_JAL = 7'b1101111,
                         C_JALR = 7'b1100111, C_ECALL = 7'b1110011;
  localparam logic [6:0] C_BUB = 7'b0110111;
  localparam int DRAIN = 3;
  localparam logic [6:0] OPS [10] = '{C_LOAD, C_STORE, C_ADD, C_ADDI, C_BR, C_JAL, C_JALR,
                                      C_ECALL, 7'b0110111, 7'b1111111};
  // {mem_read, mem_to_reg, mem_write, alu_src, write_enable, is_ecall, branch, jal, jalr, pc_to_reg, alu_op}
  localparam logic [16:0] EXPC [10] = '{
    {10'b1101100000, C_LOAD}, {10'b0011000000, C_STORE}, {10'b0000100000, C_ADD},
    {10'b0001100000, C_ADDI}, {10'b0000001000, C_BR},    {10'b0001100101, C_JAL},
    {10'b0001100011, C_JALR}, {10'b0001010000, C_ECALL}, {10'b0000000000, C_BUB},
    {10'b0000000000, C_BUB}};

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, mr, misp, hreq;
  logic [1:0] pcw, ifw, ifl, bub, hlt, mrd, m2r, mwr, asrc, we, ecl, br, jl, jr, p2r;
  logic [6:0] aop [2];
  logic [21:0] obs [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.FLUSH_DEPTH(3), .DRAIN_DEPTH(DRAIN)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_id_opcode(op), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_idex_mem_read(mr), .i_idex_rd(rd),
    .i_ex_mispredict(misp), .i_halt_req(hreq),
    .o_pc_write(pcw[0]), .o_ifid_write(ifw[0]), .o_ifid_flush(ifl[0]), .o_idex_bubble(bub[0]),
    .o_mem_read(mrd[0]), .o_mem_to_reg(m2r[0]), .o_mem_write(mwr[0]), .o_alu_src(asrc[0]),
    .o_write_enable(we[0]), .o_is_ecall(ecl[0]), .o_branch(br[0]), .o_jal(jl[0]),
    .o_jalr(jr[0]), .o_pc_to_reg(p2r[0]), .o_alu_op(aop[0]), .o_halted(hlt[0]));

  hazard_ctrl_unit #(.FLUSH_DEPTH(1), .DRAIN_DEPTH(DRAIN)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_id_opcode(op), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(u1), .i_id_use_rs2(u2), .i_idex_mem_read(mr), .i_idex_rd(rd),
    .i_ex_mispredict(misp), .i_halt_req(hreq),
    .o_pc_write(pcw[1]), .o_ifid_write(ifw[1]), .o_ifid_flush(ifl[1]), .o_idex_bubble(bub[1]),
    .o_mem_read(mrd[1]), .o_mem_to_reg(m2r[1]), .o_mem_write(mwr[1]), .o_alu_src(asrc[1]),
    .o_write_enable(we[1]), .o_is_ecall(ecl[1]), .o_branch(br[1]), .o_jal(jl[1]),
    .o_jalr(jr[1]), .o_pc_to_reg(p2r[1]), .o_alu_op(aop[1]), .o_halted(hlt[1]));

  always_comb begin
    for (int k = 0; k < 2; k++)
      obs[k] = {pcw[k], ifw[k], ifl[k], bub[k], hlt[k], mrd[k], m2r[k], mwr[k], asrc[k],
                we[k], ecl[k], br[k], jl[k], jr[k], p2r[k], aop[k]};
  end

  function automatic logic [16:0] ref_ctl(input logic [6:0] o);
    for (int i = 0; i < 8; i++) if (OPS[i] == o) return EXPC[i];
    return {10'b0, C_BUB};
  endfunction

  task automatic drive(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic m, input logic [4:0] d,
                       input logic mp, input logic hr);
    op = o; rs1 = a; rs2 = b; u1 = ua; u2 = ub; mr = m; rd = d; misp = mp; hreq = hr;
  endtask

  task automatic idle();
    drive(C_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); #2;
    checks += 4;
    if (pcw[0] !== 1'b0 || ifw[0] !== 1'b0) begin errors++; $display("FAIL reset_we: pc_write=%b ifid_write=%b expected 0 0", pcw[0], ifw[0]); end
    if (ifl[0] !== 1'b1 || bub[0] !== 1'b1) begin errors++; $display("FAIL reset_flush: ifid_flush=%b idex_bubble=%b expected 1 1", ifl[0], bub[0]); end
    if (obs[0][16:0] !== {10'b0, C_BUB}) begin errors++; $display("FAIL reset_ctl: got %h expected %h", obs[0][16:0], {10'b0, C_BUB}); end
    if (hlt[0] !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", hlt[0]); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; idle(); #2;
    checks++;
    if ({pcw[0], we[0], asrc[0]} !== 3'b110) begin errors++; $display("FAIL reset_release_add: pc/we/alu_src=%b expected 110", {pcw[0], we[0], asrc[0]}); end
    @(negedge clk); drive(C_ECALL, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #2;
    checks++;
    if ({ecl[0], bub[0], pcw[0]} !== 3'b100) begin errors++; $display("FAIL ecall_enter: ecall/bubble/pc=%b expected 100", {ecl[0], bub[0], pcw[0]}); end
    @(negedge clk); idle(); #2;
    checks++;
    if ({bub[0], pcw[0]} !== 2'b10) begin errors++; $display("FAIL drain1: bubble/pc=%b expected 10", {bub[0], pcw[0]}); end
    @(negedge clk); idle(); #2;
    rst_n = 1'b0; #1;
    checks++;
    if ({pcw[0], ifw[0], ifl[0], bub[0], hlt[0]} !== 5'b00110) begin errors++; $display("FAIL reset_mid_drain: pc/ifw/flush/bub/halted=%b expected 00110", {pcw[0], ifw[0], ifl[0], bub[0], hlt[0]}); end
    @(negedge clk); rst_n = 1'b1; idle(); #2;
    checks++;
    if ({pcw[0], bub[0], we[0], asrc[0], hlt[0]} !== 5'b10100) begin errors++; $display("FAIL reset_resume: pc/bub/we/alu_src/halted=%b expected 10100", {pcw[0], bub[0], we[0], asrc[0], hlt[0]}); end
  endtask

  task automatic test_load_use();
    @(negedge clk); drive(C_ADD, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0); #2;
    checks++;
    if ({pcw[0], ifw[0], bub[0], aop[0]} !== {3'b001, C_BUB}) begin errors++; $display("FAIL load_use_rs1: pc/ifw/bub/alu_op=%b expected %b", {pcw[0], ifw[0], bub[0], aop[0]}, {3'b001, C_BUB}); end
    @(negedge clk); drive(C_ADD, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); #2;
    checks++;
    if ({pcw[0], bub[0]} !== 2'b10) begin errors++; $display("FAIL load_use_single: pc/bub=%b expected 10", {pcw[0], bub[0]}); end
    @(negedge clk); drive(C_ADD, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    checks++;
    if ({pcw[0], bub[0]} !== 2'b10) begin errors++; $display("FAIL load_use_x0: pc/bub=%b expected 10", {pcw[0], bub[0]}); end
    @(negedge clk); drive(C_ADD, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0); #2;
    checks++;
    if ({pcw[0], bub[0]} !== 2'b10) begin errors++; $display("FAIL load_use_unused_rs2: pc/bub=%b expected 10", {pcw[0], bub[0]}); end
    @(negedge clk); drive(C_STORE, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0); #2;
    checks++;
    if ({pcw[0], bub[0], mwr[0]} !== 3'b010) begin errors++; $display("FAIL load_use_rs2: pc/bub/mem_write=%b expected 010", {pcw[0], bub[0], mwr[0]}); end
    @(negedge clk); idle();
  endtask

  task automatic test_mispredict();
    logic mp [11] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    logic e0 [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    logic e1 [11] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); drive(C_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, mp[i], 1'b0); #2;
      checks++;
      if ({ifl[0], bub[0], pcw[0], ifl[1], pcw[1]} !== {e0[i], e0[i], 1'b1, e1[i], 1'b1}) begin
        errors++;
        $display("FAIL mispredict[%0d]: flush0/bub0/pc0/flush1/pc1=%b expected %b", i,
                 {ifl[0], bub[0], pcw[0], ifl[1], pcw[1]}, {e0[i], e0[i], 1'b1, e1[i], 1'b1});
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk); drive(C_ECALL, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1); #2;
    checks++;
    if ({pcw[1], ifw[1], ifl[1], bub[1], ecl[1]} !== 5'b11110) begin errors++; $display("FAIL priority_flush: pc/ifw/flush/bub/ecall=%b expected 11110", {pcw[1], ifw[1], ifl[1], bub[1], ecl[1]}); end
    @(negedge clk); idle(); #2;
    checks++;
    if ({pcw[1], ifl[1], bub[1]} !== 3'b100) begin errors++; $display("FAIL priority_no_drain: pc/flush/bub=%b expected 100", {pcw[1], ifl[1], bub[1]}); end
    repeat (3) begin @(negedge clk); idle(); end
  endtask

  task automatic test_halt();
    @(negedge clk); drive(C_ECALL, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #2;
    checks++;
    if ({ecl[0], pcw[0], bub[0], we[0], asrc[0]} !== 5'b11001) begin errors++; $display("FAIL ecall_no_halt: ecall/pc/bub/we/alu_src=%b expected 11001", {ecl[0], pcw[0], bub[0], we[0], asrc[0]}); end
    @(negedge clk); idle(); #2;
    checks++;
    if (pcw[0] !== 1'b1) begin errors++; $display("FAIL ecall_no_halt_next: pc_write=%b expected 1", pcw[0]); end
    @(negedge clk); drive(C_ECALL, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); #2;
    checks++;
    if ({ecl[0], bub[0], pcw[0], ifw[0], aop[0]} !== {4'b1000, C_ECALL}) begin errors++; $display("FAIL halt_ecall: got %b expected %b", {ecl[0], bub[0], pcw[0], ifw[0], aop[0]}, {4'b1000, C_ECALL}); end
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk); drive(C_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'($urandom_range(0, 1)), 1'b0); #2;
      checks++;
      if ({pcw[0], ifw[0], ifl[0], bub[0], hlt[0]} !== 5'b00010) begin errors++; $display("FAIL drain[%0d]: pc/ifw/flush/bub/halted=%b expected 00010", i, {pcw[0], ifw[0], ifl[0], bub[0], hlt[0]}); end
    end
    @(negedge clk); idle(); #2;
    checks++;
    if ({pcw[0], bub[0]} !== 2'b01) begin errors++; $display("FAIL halt_entry: pc/bub=%b expected 01", {pcw[0], bub[0]}); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(C_ECALL, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0, 5'd0, 1'($urandom_range(0, 1)), 1'b1); #2;
      checks++;
      if ({hlt[0], pcw[0], ifw[0], bub[0]} !== 4'b1001) begin errors++; $display("FAIL halted[%0d]: halted/pc/ifw/bub=%b expected 1001", i, {hlt[0], pcw[0], ifw[0], bub[0]}); end
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; idle();
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(OPS[i], 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); #2;
      checks++;
      if ({bub[0], obs[0][16:0]} !== {1'b0, EXPC[i]}) begin errors++; $display("FAIL decode op=%b: bub/ctl=%h expected %h", OPS[i], {bub[0], obs[0][16:0]}, {1'b0, EXPC[i]}); end
    end
  endtask

  task automatic test_random(input int n);
    int fl [2] = '{0, 0};
    int dr [2] = '{0, 0};
    int ht [2] = '{0, 0};
    int dep [2] = '{3, 1};
    logic [21:0] e, msk;
    logic lu, ech;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0) && !(ht[0] >= 3 && ht[1] >= 3);
      drive(OPS[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      #2;
      lu  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      ech = (op == C_ECALL) && hreq;
      for (int k = 0; k < 2; k++) begin
        msk = '1;
        if (!rst_n)           e = {5'b00110, 10'b0, C_BUB};
        else if (ht[k] > 0) begin
          e = {4'b0001, (ht[k] >= 2), 10'b0, C_BUB};
          msk[19] = 1'b0;
          if (ht[k] == 1) msk[17] = 1'b0;
        end
        else if (dr[k] > 0)   e = {5'b00010, 10'b0, C_BUB};
        else if (fl[k] > 0)   e = {5'b11110, 10'b0, C_BUB};
        else if (misp)        e = {5'b11110, 10'b0, C_BUB};
        else if (lu)          e = {5'b00010, 10'b0, C_BUB};
        else if (ech)         e = {5'b00000, ref_ctl(op)};
        else                  e = {5'b11000, ref_ctl(op)};
        checks++;
        if ((obs[k] & msk) !== (e & msk)) begin
          errors++;
          $display("FAIL random inst%0d cycle %0d: got %h expected %h (mask %h)", k, c, obs[k] & msk, e & msk, msk);
        end
        if (!rst_n) begin fl[k] = 0; dr[k] = 0; ht[k] = 0; end
        else if (ht[k] > 0) ht[k] = (ht[k] < 100) ? ht[k] + 1 : ht[k];
        else if (dr[k] > 0) begin dr[k]--; if (dr[k] == 0) ht[k] = 1; end
        else if (fl[k] > 0) fl[k] = misp ? dep[k] - 1 : fl[k] - 1;
        else if (misp)      fl[k] = dep[k] - 1;
        else if (!lu && ech) dr[k] = DRAIN;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_priority();
    test_halt();
    test_decode_sweep();
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
